// File: rtl/scc_mem_arbiter.sv
// Single-port memory arbiter for the SCC: data-over-fetch grant in RUN, then a
// post-halt sequencer that streams every word of the dump range over valid/ready.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_RUN     | pipeline owns memory, data requests beat fetch
// S_DRAIN   | one idle cycle after halt so an in-flight read returns
// S_DUMP_RD | read strobe for the word at the dump pointer
// S_DUMP_WAIT | word offered on dump port until the consumer takes it
// S_DONE    | dump finished, memory idle until reset
module scc_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] DUMP_START = '0,
  parameter logic [ADDR_W-1:0] DUMP_END = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              err_misalign
);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              if_rvalid_q, if_mis_q, dm_rvalid_q, dm_mis_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, dump_data_q;
  logic              dump_valid_q, dump_fresh_q, dump_done_q, err_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic              if_mis, dm_mis;

  assign if_mis = |if_addr[1:0];
  assign dm_mis = |dm_addr[1:0];

  // Memory data arrives in the cycle after the strobe, so it is passed straight
  // through while valid and the last delivered word is held afterwards.
  assign if_rvalid    = if_rvalid_q;
  assign if_rdata     = if_rvalid_q ? (if_mis_q ? '0 : mem_rdata) : if_rdata_q;
  assign dm_rvalid    = dm_rvalid_q;
  assign dm_rdata     = dm_rvalid_q ? (dm_mis_q ? '0 : mem_rdata) : dm_rdata_q;
  assign dump_valid   = dump_valid_q;
  assign dump_addr    = dump_addr_q;
  assign dump_data    = dump_fresh_q ? mem_rdata : dump_data_q;
  assign dump_done    = dump_done_q;
  assign err_misalign = err_q;

  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_RUN: begin
        if (halt_f) begin
          state_d = S_DRAIN;
        end else begin
          dm_gnt = dm_req;
          if_gnt = if_req & ~dm_req;
          if (dm_req) begin
            if (!dm_mis) begin
              mem_en    = 1'b1;
              mem_we    = dm_we;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
            end
          end else if (if_req && !if_mis) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
      end
      S_DRAIN: state_d = S_DUMP_RD;
      S_DUMP_RD: begin
        mem_en   = 1'b1;
        mem_addr = ptr_q;
        state_d  = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (dump_valid_q && dump_ready)
          state_d = (ptr_q == DUMP_END) ? S_DONE : S_DUMP_RD;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
    if (!clk_en) begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_RUN;
      ptr_q        <= DUMP_START;
      if_rvalid_q  <= 1'b0;
      if_mis_q     <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      dm_mis_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      dump_data_q  <= '0;
      dump_addr_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_fresh_q <= 1'b0;
      dump_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      if_rvalid_q <= if_gnt;
      if_mis_q    <= if_mis;
      dm_rvalid_q <= dm_gnt & ~dm_we;
      dm_mis_q    <= dm_mis;
      if (if_rvalid_q) if_rdata_q <= if_rdata;
      if (dm_rvalid_q) dm_rdata_q <= dm_rdata;
      if ((if_gnt && if_mis) || (dm_gnt && dm_mis)) err_q <= 1'b1;

      if (state_q == S_DUMP_RD) begin
        dump_valid_q <= 1'b1;
        dump_fresh_q <= 1'b1;
        dump_addr_q  <= ptr_q;
      end else if (state_q == S_DUMP_WAIT) begin
        dump_fresh_q <= 1'b0;
        if (dump_fresh_q) dump_data_q <= mem_rdata;
        if (dump_ready) begin
          dump_valid_q <= 1'b0;
          // End check precedes the increment, so the pointer never wraps.
          if (ptr_q == DUMP_END) dump_done_q <= 1'b1;
          else                   ptr_q <= ptr_q + ADDR_W'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: grant vector table, randomized RUN traffic against a
// word-level memory model, then halt/dump, backpressure, freeze and reset sequences.
module tb_scc_mem_arbiter;
  logic        clk_tb = 1'b0;
  logic        rst, clk_en, halt_f;
  logic        if_req, if_gnt, if_rvalid;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        dump_valid, dump_ready, dump_done, err_misalign;
  logic [15:0] dump_addr;
  logic [31:0] dump_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_tb = ~clk_tb;

  scc_mem_arbiter #(
    .ADDR_W(16), .DATA_W(32), .DUMP_START(16'h0000), .DUMP_END(16'h0008)
  ) dut (
    .clk(clk_tb), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done), .err_misalign(err_misalign)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
  endfunction

  // Synchronous-read memory: 256 words, data valid the cycle after a read strobe.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  always @(posedge clk_tb) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic        exp_ifv, exp_dmv, exp_err;
  logic [31:0] exp_ifd, exp_dmd;

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_ifg;
    logic        e_dmg;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    chk({tag, "_dump_addr"}, 32'(dump_addr), 32'd0);
    chk({tag, "_dump_data"}, dump_data, 32'd0);
    chk({tag, "_dump_done"}, 32'(dump_done), 32'd0);
    chk({tag, "_err"}, 32'(err_misalign), 32'd0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 255)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // One RUN-state cycle: check against the model, then advance the model.
  task automatic run_cycle(input int vi);
    logic e_if, e_dm, mis_i, mis_d, e_en, e_we;
    logic [15:0] e_addr;
    @(negedge clk_tb);
    e_dm   = clk_en & dm_req;
    e_if   = clk_en & if_req & ~dm_req;
    mis_i  = (if_addr[1:0] != 2'b00);
    mis_d  = (dm_addr[1:0] != 2'b00);
    e_en   = (e_dm & ~mis_d) | (e_if & ~mis_i);
    e_we   = e_dm & ~mis_d & dm_we;
    e_addr = e_dm ? dm_addr : if_addr;
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", mem_wdata, dm_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
    chk("if_rdata", if_rdata, exp_ifd);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dmv));
    chk("dm_rdata", dm_rdata, exp_dmd);
    chk("err_misalign", 32'(err_misalign), 32'(exp_err));
    if (vi >= 0) begin
      chk("vec_if_gnt", 32'(if_gnt), 32'(vecs[vi].e_ifg));
      chk("vec_dm_gnt", 32'(dm_gnt), 32'(vecs[vi].e_dmg));
      chk("vec_mem_en", 32'(mem_en), 32'(vecs[vi].e_en));
      chk("vec_mem_we", 32'(mem_we), 32'(vecs[vi].e_we));
      if (vecs[vi].e_en) chk("vec_mem_addr", 32'(mem_addr), 32'(vecs[vi].e_addr));
    end
    @(posedge clk_tb);
    if (clk_en) begin
      exp_ifv = e_if;
      if (e_if) exp_ifd = mis_i ? 32'd0 : ref_mem[if_addr[9:2]];
      exp_dmv = e_dm & ~dm_we;
      if (exp_dmv) exp_dmd = mis_d ? 32'd0 : ref_mem[dm_addr[9:2]];
      if (e_we) ref_mem[dm_addr[9:2]] = dm_wdata;
      if ((e_if & mis_i) | (e_dm & mis_d)) exp_err = 1'b1;
    end
    #1;
  endtask

  // Consume a full 0x0..0x8 dump, stalling the given word for some cycles.
  task automatic dump_consume(input int stall_word, input int stall_cycles);
    int idx = 0;
    int stall_left = stall_cycles;
    int budget = 0;
    while (budget < 100) begin
      @(negedge clk_tb);
      budget++;
      if (dump_done) break;
      if (mem_en) begin
        chk("dump_mem_addr", 32'(mem_addr), 32'(idx * 4));
        chk("dump_mem_we", 32'(mem_we), 32'd0);
        chk("dump_rd_valid_low", 32'(dump_valid), 32'd0);
      end
      if (dump_valid) begin
        chk("dump_addr", 32'(dump_addr), 32'(idx * 4));
        chk("dump_data", dump_data, ref_mem[idx & 255]);
        if (idx == stall_word && stall_left > 0) begin
          dump_ready = 1'b0;
          stall_left--;
        end else begin
          dump_ready = 1'b1;
          idx++;
        end
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("dump_words", 32'(idx), 32'd3);
    chk("dump_stall_used", 32'(stall_left), 32'd0);
    chk("dump_done_set", 32'(dump_done), 32'd1);
    dump_ready = 1'b0;
  endtask

  initial begin
    bit found;
    vecs[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0004};
    vecs[1] = '{1'b1, 16'h0008, 1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100};
    vecs[2] = '{1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0008};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 16'h0100};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0102, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 16'h000C, 1'b1, 1'b1, 16'h0101, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[8] = '{1'b1, 16'h000C, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h000C};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_ifv = 0; exp_dmv = 0; exp_err = 0; exp_ifd = '0; exp_dmd = '0;

    rst = 0; clk_en = 1; halt_f = 0; dump_ready = 0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    chk_idle_outputs("reset");
    chk("reset_if_gnt", 32'(if_gnt), 32'd0);
    chk("reset_dm_gnt", 32'(dm_gnt), 32'd0);
    rst = 1;
    @(posedge clk_tb); #1;

    for (int i = 0; i < 9; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      run_cycle(i);
      if (i == 4) begin
        @(negedge clk_tb);
        chk("misalign_rvalid", 32'(dm_rvalid), 32'd1);
        chk("misalign_rdata", dm_rdata, 32'd0);
        chk("misalign_err", 32'(err_misalign), 32'd1);
        @(posedge clk_tb); #1;
      end
    end
    if_req = 0; dm_req = 0;
    run_cycle(-1);

    for (int n = 0; n < 300; n++) begin
      clk_en   = ($urandom_range(0, 4) != 0);
      if_req   = 1'($urandom_range(0, 1));
      dm_req   = ($urandom_range(0, 2) == 0);
      dm_we    = 1'($urandom_range(0, 1));
      if_addr  = rand_addr();
      dm_addr  = rand_addr();
      dm_wdata = $urandom();
      run_cycle(-1);
    end

    // Halt while a data read is in flight.
    clk_en = 1; if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
    run_cycle(-1);
    halt_f = 1; if_req = 1; dm_req = 1;
    @(negedge clk_tb);
    chk("halt_if_gnt", 32'(if_gnt), 32'd0);
    chk("halt_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("halt_mem_en", 32'(mem_en), 32'd0);
    chk("halt_rvalid", 32'(dm_rvalid), 32'd1);
    chk("halt_rdata", dm_rdata, ref_mem[4]);
    @(posedge clk_tb); #1;
    halt_f = 0;
    @(negedge clk_tb);
    chk("drain_mem_en", 32'(mem_en), 32'd0);
    chk("drain_gnt", 32'(if_gnt | dm_gnt), 32'd0);
    chk("drain_rvalid", 32'(dm_rvalid), 32'd0);
    @(posedge clk_tb); #1;
    if_req = 0; dm_req = 0;
    dump_consume(1, 3);
    repeat (3) begin
      @(negedge clk_tb);
      chk("done_sticky", 32'(dump_done), 32'd1);
      chk("done_mem_en", 32'(mem_en), 32'd0);
      chk("done_valid", 32'(dump_valid), 32'd0);
    end

    // Second dump: freeze mid-word, then reset mid-dump.
    rst = 0;
    @(posedge clk_tb);
    @(negedge clk_tb);
    chk_idle_outputs("rst_after_done");
    rst = 1; halt_f = 1; dump_ready = 1;
    found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_tb);
      if (dump_valid && dump_addr == 16'h0004) begin
        dump_ready = 0;
        found = 1;
        break;
      end
    end
    chk("reach_word1", 32'(found), 32'd1);
    clk_en = 0; dump_ready = 1;
    repeat (4) begin
      @(negedge clk_tb);
      chk("freeze_valid", 32'(dump_valid), 32'd1);
      chk("freeze_addr", 32'(dump_addr), 32'h4);
      chk("freeze_data", dump_data, ref_mem[1]);
      chk("freeze_mem_en", 32'(mem_en), 32'd0);
      chk("freeze_done", 32'(dump_done), 32'd0);
    end
    clk_en = 1; dump_ready = 0;
    @(negedge clk_tb);
    chk("unfreeze_valid", 32'(dump_valid), 32'd1);
    chk("unfreeze_addr", 32'(dump_addr), 32'h4);
    chk("unfreeze_data", dump_data, ref_mem[1]);
    rst = 0;
    @(negedge clk_tb);
    chk_idle_outputs("rst_mid_dump");
    rst = 1;
    @(negedge clk_tb);
    chk("restart_drain_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk_tb);
    chk("restart_mem_en", 32'(mem_en), 32'd1);
    chk("restart_mem_addr", 32'(mem_addr), 32'h0);
    chk("restart_done", 32'(dump_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
